// File: rtl/inv_arbiter.sv
// inv_arbiter: shares one Montgomery inverter between two requesters.
//
// A round-robin FSM (IDLE -> ISSUE -> WAIT -> RESP) grants one port at a time,
// latches its operand into inv_X, runs the inverter's request/result handshake,
// and holds the result on R until the owning port accepts it. A zero operand
// is answered locally with R = 0, err = 1 and never reaches the inverter.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   M                           modulus, forwarded combinationally to inv_M
//   req_valid0/1, X0/X1         requests and operands from port 0/1
//   req_ready0/1                one-cycle accept pulse per granted request
//   res_valid0/1, res_ready0/1  result handshake per port (owner only)
//   R, err                      result and zero-operand flag
//   busy                        high whenever the FSM is not in IDLE
//   inv_rst                     active-high inverter reset (sync release)
//   inv_X, inv_M                operand and modulus to the inverter
//   inv_req_valid/inv_req_ready request handshake to the inverter
//   inv_req_busy                inverter busy, monitored only
//   inv_res_valid/inv_res_ready result handshake from the inverter
//   inv_R                       inverter result
module inv_arbiter #(
  parameter int unsigned N = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] M,
  input  logic         req_valid0,
  input  logic [N-1:0] X0,
  output logic         req_ready0,
  input  logic         req_valid1,
  input  logic [N-1:0] X1,
  output logic         req_ready1,
  output logic         res_valid0,
  input  logic         res_ready0,
  output logic         res_valid1,
  input  logic         res_ready1,
  output logic [N-1:0] R,
  output logic         err,
  output logic         busy,
  output logic         inv_rst,
  output logic [N-1:0] inv_X,
  output logic [N-1:0] inv_M,
  output logic         inv_req_valid,
  input  logic         inv_req_ready,
  input  logic         inv_req_busy,
  input  logic         inv_res_valid,
  output logic         inv_res_ready,
  input  logic [N-1:0] inv_R
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e       r_state;
  logic [1:0]   r_rst_sync;
  logic         r_rr;
  logic         r_owner;
  logic [N-1:0] r_inv_x;
  logic [N-1:0] r_r;
  logic         r_err;
  logic         r_req_ready0;
  logic         r_req_ready1;
  logic         r_res_valid0;
  logic         r_res_valid1;
  logic         r_inv_req_valid;
  logic         r_inv_res_ready;

  logic         w_grant_any;
  logic         w_grant_sel;
  logic [N-1:0] w_grant_x;
  logic         w_res_ready_own;

  // No grant while the inverter is still held in reset.
  assign w_grant_any     = (req_valid0 | req_valid1) & ~r_rst_sync[1];
  // Contention goes to the pointer; a lone requester always wins.
  assign w_grant_sel     = (req_valid0 & req_valid1) ? r_rr : req_valid1;
  assign w_grant_x       = w_grant_sel ? X1 : X0;
  assign w_res_ready_own = r_owner ? res_ready1 : res_ready0;

  // Inverter reset: asserts with rst_n, releases on the second clock after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_rr            <= 1'b0;
      r_owner         <= 1'b0;
      r_inv_x         <= '0;
      r_r             <= '0;
      r_err           <= 1'b0;
      r_req_ready0    <= 1'b0;
      r_req_ready1    <= 1'b0;
      r_res_valid0    <= 1'b0;
      r_res_valid1    <= 1'b0;
      r_inv_req_valid <= 1'b0;
      r_inv_res_ready <= 1'b0;
    end else begin
      // Pulsed outputs default low every cycle.
      r_req_ready0    <= 1'b0;
      r_req_ready1    <= 1'b0;
      r_inv_res_ready <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_grant_any) begin
            r_owner      <= w_grant_sel;
            r_inv_x      <= w_grant_x;
            r_req_ready0 <= ~w_grant_sel;
            r_req_ready1 <= w_grant_sel;
            if (w_grant_x == '0) begin
              // Zero has no inverse: answer locally, inverter untouched.
              r_r          <= '0;
              r_err        <= 1'b1;
              r_res_valid0 <= ~w_grant_sel;
              r_res_valid1 <= w_grant_sel;
              r_state      <= StResp;
            end else begin
              r_inv_req_valid <= 1'b1;
              r_err           <= 1'b0;
              r_state         <= StIssue;
            end
          end
        end
        StIssue: begin
          if (inv_req_ready) begin
            r_inv_req_valid <= 1'b0;
            r_state         <= StWait;
          end
        end
        StWait: begin
          if (inv_res_valid) begin
            r_r             <= inv_R;
            r_inv_res_ready <= 1'b1;
            r_res_valid0    <= ~r_owner;
            r_res_valid1    <= r_owner;
            r_state         <= StResp;
          end
        end
        StResp: begin
          if (w_res_ready_own) begin
            r_res_valid0 <= 1'b0;
            r_res_valid1 <= 1'b0;
            r_rr         <= ~r_owner;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready0    = r_req_ready0;
  assign req_ready1    = r_req_ready1;
  assign res_valid0    = r_res_valid0;
  assign res_valid1    = r_res_valid1;
  assign R             = r_r;
  assign err           = r_err;
  assign busy          = (r_state != StIdle);
  assign inv_rst       = r_rst_sync[1];
  assign inv_X         = r_inv_x;
  assign inv_M         = M;
  assign inv_req_valid = r_inv_req_valid;
  assign inv_res_ready = r_inv_res_ready;

  // A request must never be offered to a busy inverter outside the issue window.
  a_no_issue_while_busy : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state != StIssue) |-> !(inv_req_valid && inv_req_busy));

endmodule

// File: tb/tb_inv_arbiter.sv
// tb_inv_arbiter: self-checking bench for inv_arbiter with a stand-in inverter.
module tb_inv_arbiter;
  localparam int unsigned N = 255;
  localparam logic [N-1:0] P25519 = {N{1'b1}} - 255'd18;
  localparam logic [N-1:0] KEY = 255'h1d2c_3b4a_5968_7786_95a4_c3b2_a190;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] M = P25519;
  logic         req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic [N-1:0] X0 = '0, X1 = '0;
  logic         req_ready0, req_ready1, res_valid0, res_valid1;
  logic         res_ready0 = 1'b0, res_ready1 = 1'b0;
  logic [N-1:0] R, inv_X, inv_M, inv_R;
  logic         err, busy, inv_rst, inv_req_valid, inv_res_ready;
  logic         inv_req_ready, inv_req_busy, inv_res_valid;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  inv_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .M(M),
    .req_valid0(req_valid0), .X0(X0), .req_ready0(req_ready0),
    .req_valid1(req_valid1), .X1(X1), .req_ready1(req_ready1),
    .res_valid0(res_valid0), .res_ready0(res_ready0),
    .res_valid1(res_valid1), .res_ready1(res_ready1),
    .R(R), .err(err), .busy(busy), .inv_rst(inv_rst),
    .inv_X(inv_X), .inv_M(inv_M),
    .inv_req_valid(inv_req_valid), .inv_req_ready(inv_req_ready),
    .inv_req_busy(inv_req_busy), .inv_res_valid(inv_res_valid),
    .inv_res_ready(inv_res_ready), .inv_R(inv_R)
  );

  // Stand-in inverter: distinct, easily predicted result per operand.
  function automatic logic [N-1:0] mock_inv(input logic [N-1:0] x);
    return {x[N-2:0], x[N-1]} ^ KEY;
  endfunction

  function automatic logic [N-1:0] expect_r(input logic [N-1:0] x);
    return (x == '0) ? '0 : mock_inv(x);
  endfunction

  // Inverter model: accept -> ready pulse next cycle, busy until result taken.
  logic         m_busy, m_ready, m_res_valid;
  logic [N-1:0] m_x;
  int           m_cnt;
  int           m_lat = 2;   // negative selects a random latency per request
  assign inv_req_ready = m_ready;
  assign inv_req_busy  = m_busy;
  assign inv_res_valid = m_res_valid;
  assign inv_R         = mock_inv(m_x);

  always @(posedge clk or posedge inv_rst) begin
    if (inv_rst) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_res_valid <= 1'b0; m_cnt <= 0; m_x <= '0;
    end else begin
      m_ready <= 1'b0;
      if (!m_busy) begin
        if (inv_req_valid) begin
          m_busy  <= 1'b1;
          m_ready <= 1'b1;
          m_x     <= inv_X;
          m_cnt   <= (m_lat < 0) ? int'($urandom_range(0, 6)) : m_lat;
        end
      end else if (m_res_valid) begin
        if (inv_res_ready) begin
          m_res_valid <= 1'b0;
          m_busy      <= 1'b0;
        end
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
      end else begin
        m_res_valid <= 1'b1;
      end
    end
  end

  // Protocol monitor and round-robin reference: the pointer favours the port
  // that was not served by the last completed transaction.
  int ivr_cnt = 0, irr_cnt = 0, viol = 0, unstable = 0;
  int cur_owner = 0, rr_m = 0;
  int grants_seen[2];
  int issued[2];
  int grant_q[$];
  logic pv0 = 1'b0, pv1 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rr_m = 0; pv0 = 1'b0; pv1 = 1'b0;
    end else begin
      if (inv_req_valid) ivr_cnt++;
      if (inv_res_ready) irr_cnt++;
      if (inv_req_valid && inv_req_busy && !inv_req_ready) viol++;
      if (res_valid0 && res_valid1) viol++;
      if (req_ready0 && req_ready1) viol++;
      if (req_ready0 || req_ready1) begin
        cur_owner = req_ready1 ? 1 : 0;
        grant_q.push_back(cur_owner);
        grants_seen[cur_owner]++;
        if (pv0 && pv1) begin
          n_tests++;
          if (cur_owner != rr_m) begin
            n_fail++;
            $display("FAIL rr_grant: granted port %0d, required port %0d", cur_owner, rr_m);
          end
        end
      end
      if ((res_valid0 && cur_owner != 0) || (res_valid1 && cur_owner != 1)) viol++;
      if (res_valid0 && res_ready0) rr_m = 1;
      if (res_valid1 && res_ready1) rr_m = 0;
      pv0 = req_valid0;
      pv1 = req_valid1;
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int p, input logic v, input logic [N-1:0] x);
    if (p == 0) begin req_valid0 = v; X0 = x; end
    else begin req_valid1 = v; X1 = x; end
  endtask

  task automatic drive_rdy(input int p, input logic v);
    if (p == 0) res_ready0 = v;
    else res_ready1 = v;
  endtask

  function automatic logic ready_of(input int p);
    return (p == 0) ? req_ready0 : req_ready1;
  endfunction

  function automatic logic resv_of(input int p);
    return (p == 0) ? res_valid0 : res_valid1;
  endfunction

  // One transaction on port p; latencies are counted in cycles from the request.
  task automatic do_txn(input int p, input logic [N-1:0] x, input int hold,
                        output logic [N-1:0] r, output logic e, output int acc_lat,
                        output int res_lat, output int n_ivr, output int n_irr);
    int c, ivr0, irr0;
    ivr0 = ivr_cnt;
    irr0 = irr_cnt;
    drive_req(p, 1'b1, x);
    c = 0;
    do begin step(); c++; end while (!ready_of(p) && c < 500);
    acc_lat = ready_of(p) ? c : -1;
    drive_req(p, 1'b0, x);
    while (!resv_of(p) && c < 3000) begin step(); c++; end
    res_lat = resv_of(p) ? c : -1;
    r = R;
    e = err;
    for (int i = 0; i < hold; i++) begin
      step();
      if (R !== r || err !== e || resv_of(p) !== 1'b1) unstable++;
    end
    drive_rdy(p, 1'b1);
    step();
    drive_rdy(p, 1'b0);
    n_ivr = ivr_cnt - ivr0;
    n_irr = irr_cnt - irr0;
  endtask

  function automatic logic [N-1:0] rand_x();
    logic [N-1:0] v = '0;
    if ($urandom_range(0, 5) == 0) return '0;
    for (int i = 0; i < 8; i++) v = {v[N-33:0], $urandom};
    if (v == '0) v = 1;
    return v;
  endfunction

  task automatic port_loop(input int p, input int n, input bit rnd, input logic [N-1:0] fx);
    logic [N-1:0] x, r;
    logic e;
    int a, rl, ni, nr, hold;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        for (int g = int'($urandom_range(0, 3)); g > 0; g--) step();
      end
      x = rnd ? rand_x() : fx;
      hold = rnd ? int'($urandom_range(0, 4)) : 0;
      do_txn(p, x, hold, r, e, a, rl, ni, nr);
      issued[p]++;
      check(p == 0 ? "port0 R" : "port1 R", r, expect_r(x));
      check_int(p == 0 ? "port0 err" : "port1 err", int'(e), int'(x == '0));
    end
  endtask

  typedef struct {
    int p; logic [N-1:0] x; int lat; int hold;
    logic [N-1:0] exp_r; int exp_err; int exp_acc; int exp_res; int exp_ivr; int exp_irr;
  } vec_t;

  vec_t         vecs[5];
  logic [N-1:0] tr, r0, r1;
  logic         te, e0, e1;
  int           ta, trl, tni, tnr, a0, rl0, ni0, nr0, a1, rl1, ni1, nr1, c;

  initial begin
    vecs[0] = '{0, 255'd1, 3, 0, mock_inv(255'd1), 0, 1, 7, 2, 1};
    vecs[1] = '{1, 255'd0, 3, 2, '0, 1, 1, 1, 0, 0};
    vecs[2] = '{1, P25519 - 1, 0, 1, mock_inv(P25519 - 1), 0, 1, 4, 2, 1};
    vecs[3] = '{0, 255'd0, 0, 0, '0, 1, 1, 1, 0, 0};
    vecs[4] = '{0, 255'hdead_beef_0123_4567, 10, 3, mock_inv(255'hdead_beef_0123_4567),
                0, 1, 14, 2, 1};

    // Reset values.
    #1 rst_n = 1'b0;
    #2;
    check_int("rst req_ready0", int'(req_ready0), 0);
    check_int("rst req_ready1", int'(req_ready1), 0);
    check_int("rst res_valid0", int'(res_valid0), 0);
    check_int("rst res_valid1", int'(res_valid1), 0);
    check("rst R", R, '0);
    check_int("rst err", int'(err), 0);
    check_int("rst busy", int'(busy), 0);
    check_int("rst inv_rst", int'(inv_rst), 1);
    check("rst inv_X", inv_X, '0);
    check_int("rst inv_req_valid", int'(inv_req_valid), 0);
    check_int("rst inv_res_ready", int'(inv_res_ready), 0);
    check("inv_M passthrough", inv_M, P25519);
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();

    // Contention straight after reset: port 0 first, then strict alternation.
    grant_q.delete();
    m_lat = 1;
    fork
      port_loop(0, 2, 1'b0, 255'd5);
      port_loop(1, 2, 1'b0, 255'd7);
    join
    check_int("contention grants", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++) check_int("contention order", grant_q[i], i % 2);

    // Single-port vectors with timing and inverter handshake counts.
    for (int i = 0; i < 5; i++) begin
      m_lat = vecs[i].lat;
      repeat (2) step();
      do_txn(vecs[i].p, vecs[i].x, vecs[i].hold, tr, te, ta, trl, tni, tnr);
      check("vec R", tr, vecs[i].exp_r);
      check_int("vec err", int'(te), vecs[i].exp_err);
      check_int("vec req_ready latency", ta, vecs[i].exp_acc);
      check_int("vec res_valid latency", trl, vecs[i].exp_res);
      check_int("vec inv_req_valid cycles", tni, vecs[i].exp_ivr);
      check_int("vec inv_res_ready cycles", tnr, vecs[i].exp_irr);
    end

    // Back-pressure: port 0 holds its result 50 cycles; port 1 must wait.
    m_lat = 2;
    unstable = 0;
    fork
      do_txn(0, 255'd9, 50, r0, e0, a0, rl0, ni0, nr0);
      begin
        c = 0;
        while (!res_valid0 && c < 200) begin step(); c++; end
        do_txn(1, 255'd11, 0, r1, e1, a1, rl1, ni1, nr1);
      end
    join
    check("bp port0 R", r0, mock_inv(255'd9));
    check("bp port1 R", r1, mock_inv(255'd11));
    check_int("bp port1 grant wait", a1, 52);
    check_int("bp hold stability", unstable, 0);

    // Reset while waiting for the inverter.
    m_lat = 20;
    repeat (2) step();
    drive_req(0, 1'b1, 255'd13);
    c = 0;
    do begin step(); c++; end while (!req_ready0 && c < 50);
    drive_req(0, 1'b0, 255'd13);
    repeat (5) step();
    check_int("busy in wait", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_int("midrst req_ready0", int'(req_ready0), 0);
    check_int("midrst res_valid0", int'(res_valid0), 0);
    check_int("midrst res_valid1", int'(res_valid1), 0);
    check("midrst R", R, '0);
    check_int("midrst err", int'(err), 0);
    check_int("midrst busy", int'(busy), 0);
    check_int("midrst inv_rst", int'(inv_rst), 1);
    check("midrst inv_X", inv_X, '0);
    check_int("midrst inv_req_valid", int'(inv_req_valid), 0);
    check_int("midrst inv_res_ready", int'(inv_res_ready), 0);
    step();
    rst_n = 1'b1;
    m_lat = 2;
    drive_req(1, 1'b1, 255'd3);
    step();
    check_int("inv_rst edge1", int'(inv_rst), 1);
    check_int("no grant edge1", int'(req_ready1), 0);
    step();
    check_int("inv_rst edge2", int'(inv_rst), 0);
    check_int("no grant edge2", int'(req_ready1), 0);
    step();
    check_int("grant after inv_rst", int'(req_ready1), 1);
    drive_req(1, 1'b0, 255'd3);
    c = 0;
    while (!res_valid1 && c < 100) begin step(); c++; end
    check_int("post-reset res_valid1", int'(res_valid1), 1);
    check("post-reset R", R, mock_inv(255'd3));
    check_int("post-reset err", int'(err), 0);
    res_ready1 = 1'b1;
    step();
    res_ready1 = 1'b0;

    // Randomised traffic on both ports, random inverter latency.
    m_lat = -1;
    unstable = 0;
    grants_seen[0] = 0; grants_seen[1] = 0;
    issued[0] = 0; issued[1] = 0;
    fork
      port_loop(0, 12, 1'b1, '0);
      port_loop(1, 12, 1'b1, '0);
    join
    check_int("rand grants port0", grants_seen[0], issued[0]);
    check_int("rand grants port1", grants_seen[1], issued[1]);
    check_int("rand hold stability", unstable, 0);
    check_int("protocol violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
